// File: rtl/acc_param.sv
// Block accumulator: sums/subtracts IN_W-bit samples over BLOCK_LEN accepts, then hands the result off over a valid/ready port.
// Optional feature: define ACC_SATURATE_EN to clamp on overflow/underflow instead of wrapping.
module acc_param #(
    parameter int unsigned IN_W      = 4,
    parameter int unsigned ACC_W     = 8,
    parameter int unsigned BLOCK_LEN = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [IN_W-1:0]                    in,
    input  logic                               sub,
    input  logic                               clr,
    output logic [ACC_W-1:0]                   acc,
    output logic [$clog2(BLOCK_LEN+1)-1:0]     cnt,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ACC_W-1:0]                   out_data,
    output logic                               out_ovf
);

    localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 1);
    localparam int unsigned SUM_W = ACC_W + 1;

    logic             accept;
    logic             blk_done;
    logic [SUM_W-1:0] raw;
    logic             ovf_now;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_blk;

    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_blk_d;
    logic             out_valid_d;
    logic [ACC_W-1:0] out_data_d;
    logic             out_ovf_d;

    // Output slot is free when empty or being drained this edge; clr blocks intake
    assign in_ready = (!out_valid || out_ready) && !clr;
    assign accept   = in_valid && in_ready;
    assign blk_done = accept && (cnt == CNT_W'(BLOCK_LEN - 1));

    // One extra bit catches both carry-out on add and borrow on subtract
    always_comb begin
        raw      = '0;
        ovf_now  = 1'b0;
        acc_next = '0;
        if (sub) begin
            raw = {1'b0, acc} - SUM_W'(in);
        end else begin
            raw = {1'b0, acc} + SUM_W'(in);
        end
        ovf_now = raw[ACC_W];
`ifdef ACC_SATURATE_EN
        if (ovf_now) begin
            acc_next = sub ? '0 : '1;
        end else begin
            acc_next = raw[ACC_W-1:0];
        end
`else
        acc_next = raw[ACC_W-1:0];
`endif
    end

    always_comb begin
        acc_d       = acc;
        cnt_d       = cnt;
        ovf_blk_d   = ovf_blk;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_ovf_d   = out_ovf;

        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clr) begin
            acc_d     = '0;
            cnt_d     = '0;
            ovf_blk_d = 1'b0;
        end else if (accept) begin
            if (blk_done) begin
                // Completion overrides a same-edge drain so the result slot never bubbles
                out_data_d  = acc_next;
                out_ovf_d   = ovf_blk | ovf_now;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_blk_d   = 1'b0;
            end else begin
                acc_d     = acc_next;
                cnt_d     = cnt + CNT_W'(1);
                ovf_blk_d = ovf_blk | ovf_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf_blk   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            acc       <= acc_d;
            cnt       <= cnt_d;
            ovf_blk   <= ovf_blk_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_ovf   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_acc_param.sv
// Directed, table-driven bench for acc_param (defaults) plus a BLOCK_LEN=1 instance for back-to-back results.
module tb_acc_param;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] din;
    logic       sub;
    logic       clr;
    logic [7:0] acc;
    logic [2:0] cnt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;

    logic       b_rst;
    logic       b_in_valid;
    logic       b_in_ready;
    logic [3:0] b_din;
    logic       b_sub;
    logic       b_clr;
    logic [7:0] b_acc;
    logic [0:0] b_cnt;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [7:0] b_out_data;
    logic       b_out_ovf;

    int n_cmp;
    int n_bad;

`ifdef ACC_SATURATE_EN
    localparam logic [7:0] U0 = 8'd0;
    localparam logic [7:0] U1 = 8'd1;
    localparam logic [7:0] U2 = 8'd2;
    localparam logic [7:0] U3 = 8'd3;
    localparam logic [7:0] BSUB = 8'd0;
`else
    localparam logic [7:0] U0 = 8'd251;
    localparam logic [7:0] U1 = 8'd252;
    localparam logic [7:0] U2 = 8'd253;
    localparam logic [7:0] U3 = 8'd254;
    localparam logic [7:0] BSUB = 8'd253;
`endif

    acc_param dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(din),
        .sub(sub), .clr(clr), .acc(acc), .cnt(cnt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    acc_param #(.IN_W(4), .ACC_W(8), .BLOCK_LEN(1)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_din),
        .sub(b_sub), .clr(b_clr), .acc(b_acc), .cnt(b_cnt), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_ovf(b_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] din;
        logic       sub;
        logic       clr;
        logic       ordy;
        logic       e_rdy;
        logic [7:0] e_acc;
        logic [2:0] e_cnt;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_oo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic iv, logic [3:0] d, logic s, logic c, logic o,
                                logic er, logic [7:0] ea, logic [2:0] ec, logic ev,
                                logic [7:0] eod, logic eoo);
        vec_t v;
        v.rst = r; v.iv = iv; v.din = d; v.sub = s; v.clr = c; v.ordy = o;
        v.e_rdy = er; v.e_acc = ea; v.e_cnt = ec; v.e_ov = ev; v.e_od = eod; v.e_oo = eoo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0; in_valid = 1'b0; din = '0; sub = 1'b0; clr = 1'b0; out_ready = 1'b0;
        b_rst = 1'b0; b_in_valid = 1'b0; b_din = '0; b_sub = 1'b0; b_clr = 1'b0; b_out_ready = 1'b0;

        //             rst iv din sub clr ordy | rdy acc cnt ov  od  oo
        // Reset held 5 cycles with a sample offered
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Basic block 3+4+5+6
        vecs.push_back(mk(1, 1, 3, 0, 0, 1, 1,  3, 1, 0,  0, 0));
        vecs.push_back(mk(1, 1, 4, 0, 0, 1, 1,  7, 2, 0,  0, 0));
        vecs.push_back(mk(1, 1, 5, 0, 0, 1, 1, 12, 3, 0,  0, 0));
        vecs.push_back(mk(1, 1, 6, 0, 0, 1, 1,  0, 0, 1, 18, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 18, 0));
        // Backpressure: complete 1+2+3+4 with out_ready low, hold 5 cycles
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  1, 1, 0, 18, 0));
        vecs.push_back(mk(1, 1, 2, 0, 0, 0, 1,  3, 2, 0, 18, 0));
        vecs.push_back(mk(1, 1, 3, 0, 0, 0, 1,  6, 3, 0, 18, 0));
        vecs.push_back(mk(1, 1, 4, 0, 0, 0, 1,  0, 0, 1, 10, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 1, 10, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 10, 0));
        // Underflow 0-5, then +1 x3
        vecs.push_back(mk(1, 1, 5, 1, 0, 1, 1, U0, 1, 0, 10, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1, U1, 2, 0, 10, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1, U2, 3, 0, 10, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1,  0, 0, 1, U3, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1,  0, 0, 0, U3, 1));
        // Clear: 7,7, clr, then 1,1,1,1
        vecs.push_back(mk(1, 1, 7, 0, 0, 1, 1,  7, 1, 0, U3, 1));
        vecs.push_back(mk(1, 1, 7, 0, 0, 1, 1, 14, 2, 0, U3, 1));
        vecs.push_back(mk(1, 1, 7, 0, 1, 1, 0,  0, 0, 0, U3, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1,  1, 1, 0, U3, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1,  2, 2, 0, U3, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1,  3, 3, 0, U3, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  0, 0, 1,  4, 0));
        // clr leaves a pending result untouched
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0,  0, 0, 1,  4, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1,  0, 0, 0,  4, 0));
        // Mid-block reset: 9,9, rst, then 2,2,2,2
        vecs.push_back(mk(1, 1, 9, 0, 0, 1, 1,  9, 1, 0,  4, 0));
        vecs.push_back(mk(1, 1, 9, 0, 0, 1, 1, 18, 2, 0,  4, 0));
        vecs.push_back(mk(0, 1, 9, 0, 0, 1, 1,  0, 0, 0,  0, 0));
        vecs.push_back(mk(1, 1, 2, 0, 0, 1, 1,  2, 1, 0,  0, 0));
        vecs.push_back(mk(1, 1, 2, 0, 0, 1, 1,  4, 2, 0,  0, 0));
        vecs.push_back(mk(1, 1, 2, 0, 0, 1, 1,  6, 3, 0,  0, 0));
        vecs.push_back(mk(1, 1, 2, 0, 0, 0, 1,  0, 0, 1,  8, 0));
        // Reset discards a pending result
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0));
        // in_valid low holds acc/cnt
        vecs.push_back(mk(1, 1, 4, 0, 0, 0, 1,  4, 1, 0,  0, 0));
        vecs.push_back(mk(1, 0, 9, 0, 0, 0, 1,  4, 1, 0,  0, 0));
        vecs.push_back(mk(1, 0, 9, 1, 0, 1, 1,  4, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0));

        @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; in_valid = vecs[i].iv; din = vecs[i].din;
            sub = vecs[i].sub; clr = vecs[i].clr; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d acc", i), 32'(acc), 32'(vecs[i].e_acc));
            chk($sformatf("v%0d cnt", i), 32'(cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            chk($sformatf("v%0d out_ovf", i), 32'(out_ovf), 32'(vecs[i].e_oo));
        end

        // Streaming block of ones: result must appear after exactly 4 edges
        begin
            int cycles;
            cycles = 0;
            @(negedge clk);
            rst = 1'b1; in_valid = 1'b1; din = 4'd1; sub = 1'b0; clr = 1'b0; out_ready = 1'b1;
            while (cycles < 20) begin
                @(posedge clk);
                #1;
                cycles++;
                if (out_valid) break;
            end
            chk("stream latency", 32'(cycles), 32'd4);
            chk("stream out_data", 32'(out_data), 32'd4);
            @(negedge clk);
            in_valid = 1'b0;
        end

        // BLOCK_LEN=1: every accept completes; completion on a drain edge must not bubble
        @(negedge clk);
        b_rst = 1'b1; b_in_valid = 1'b1; b_din = 4'd5; b_out_ready = 1'b0;
        #1 chk("b first in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;
        chk("b first out_valid", 32'(b_out_valid), 32'd1);
        chk("b first out_data", 32'(b_out_data), 32'd5);
        @(negedge clk);
        b_din = 4'd6;
        #1 chk("b stall in_ready", 32'(b_in_ready), 32'd0);
        @(posedge clk); #1;
        chk("b stall out_data", 32'(b_out_data), 32'd5);
        chk("b stall acc", 32'(b_acc), 32'd0);
        @(negedge clk);
        b_din = 4'd7; b_out_ready = 1'b1;
        #1 chk("b swap in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;
        chk("b swap out_valid", 32'(b_out_valid), 32'd1);
        chk("b swap out_data", 32'(b_out_data), 32'd7);
        @(negedge clk);
        b_din = 4'd3; b_sub = 1'b1;
        @(posedge clk); #1;
        chk("b sub out_data", 32'(b_out_data), 32'(BSUB));
        chk("b sub out_ovf", 32'(b_out_ovf), 32'd1);
        chk("b sub cnt", 32'(b_cnt), 32'd0);
        @(negedge clk);
        b_in_valid = 1'b0; b_sub = 1'b0;
        @(posedge clk); #1;
        chk("b drain out_valid", 32'(b_out_valid), 32'd0);
        chk("b drain out_ovf", 32'(b_out_ovf), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
